hash_receiver: RTL



---
 rtl/hash_receiver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hash_receiver.sv
// Receive side of the string-checker hash link: reassembles an LSB-first byte stream
// into a NUM_BYTES-byte hash and flags malformed frames. Optional ARMED timeout: RX_TIMEOUT_EN.
module hash_receiver #(
    parameter int NUM_BYTES = 8,
    parameter int BYTE_W    = 8
`ifdef RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [BYTE_W-1:0]           hashData,
    input  logic                        z1,
    input  logic                        z2,
    output logic [NUM_BYTES*BYTE_W-1:0] HashOut,
    output logic                        HashValid,
    output logic                        WordSeen,
    output logic                        FrameError,
    output logic                        Busy,
    output logic [3:0]                  ByteCount
);

    localparam int HASH_W = NUM_BYTES * BYTE_W;
    // Only the bytes still waiting for the final one are held; the last byte goes straight to HashOut.
    localparam int SHR_W  = (NUM_BYTES - 1) * BYTE_W;
    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);
    localparam logic [3:0] FULL_CNT = 4'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RECV  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SHR_W-1:0]   shreg_q, shreg_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               seen_q, seen_d;
    logic               long_q, long_d;
    logic [SHR_W-1:0]   shift_in;

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

    assign shift_in = {hashData, shreg_q[SHR_W-1:BYTE_W]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        hash_d  = hash_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        seen_d  = seen_q;
        long_d  = long_q;
`ifdef RX_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (z1) begin
                    shreg_d = shift_in;
                    cnt_d   = 4'd1;
                    state_d = RECV;
                end else if (z2) begin
                    seen_d  = 1'b1;
                    state_d = ARMED;
`ifdef RX_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ARMED: begin
                if (z1) begin
                    shreg_d = shift_in;
                    cnt_d   = 4'd1;
                    seen_d  = 1'b0;
                    state_d = RECV;
                end
`ifdef RX_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    seen_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
`endif
            end
            RECV: begin
                if (z1) begin
                    shreg_d = shift_in;
                    if (cnt_q == LAST_IDX) begin
                        hash_d  = {hashData, shreg_q};
                        valid_d = 1'b1;
                        cnt_d   = FULL_CNT;
                        long_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Extra bytes of a long frame are dropped; the error is reported only once.
                if (!z1) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (!long_q) begin
                    err_d   = 1'b1;
                    long_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shreg_q <= '0;
            hash_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            hash_q  <= hash_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            long_q  <= long_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign HashOut    = hash_q;
    assign HashValid  = valid_q;
    assign WordSeen   = seen_q;
    assign FrameError = err_q;
    assign ByteCount  = cnt_q;
    assign Busy       = (state_q == RECV) || (state_q == DRAIN);

endmodule
